// File: rtl/apb_rr_arbiter_if.sv
// ----------------------------------------------------------------
// apb_rr_arbiter_if: requester-side and APB-side bundle of the arbiter
// Rev 1.0
// ----------------------------------------------------------------
`default_nettype none

interface apb_rr_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_REQ    = 4
);
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ-1:0]            req_write;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]            gnt;
  logic [NUM_REQ-1:0]            done;
  logic [DATA_WIDTH-1:0]         rdata;
  logic                          err;
  logic                          psel;
  logic                          penable;
  logic                          pwrite;
  logic [ADDR_WIDTH-1:0]         paddr;
  logic [DATA_WIDTH-1:0]         pwdata;
  logic [DATA_WIDTH-1:0]         prdata;
  logic                          pready;
  logic                          pslverr;

  // master: the arbiter itself; slave: requesters plus APB fabric around it
  modport master (
    input  req, req_write, req_addr, req_wdata, prdata, pready, pslverr,
    output gnt, done, rdata, err, psel, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output req, req_write, req_addr, req_wdata, prdata, pready, pslverr,
    input  gnt, done, rdata, err, psel, penable, pwrite, paddr, pwdata
  );
endinterface

`default_nettype wire

// File: rtl/apb_rr_arbiter.sv
// ----------------------------------------------------------------
// apb_rr_arbiter: round-robin arbiter sharing one APB master port
// Rev 1.0
// ----------------------------------------------------------------
`default_nettype none

module apb_rr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int TIMEOUT    = 16
) (
  input  wire                pclk,
  input  wire                rst,
  apb_rr_arbiter_if.master   bus
);

  localparam int WIN_W = $clog2(NUM_REQ);
  localparam int CNT_W = ($clog2(TIMEOUT + 1) < 1) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2} state_t;

  state_t                r_state, w_state;
  logic [WIN_W-1:0]      r_last, w_last, r_win, w_win;
  logic [CNT_W-1:0]      r_cnt, w_cnt;
  logic                  r_psel, w_psel, r_penable, w_penable, r_pwrite, w_pwrite;
  logic [ADDR_WIDTH-1:0] r_paddr, w_paddr;
  logic [DATA_WIDTH-1:0] r_pwdata, w_pwdata, r_rdata, w_rdata;
  logic [NUM_REQ-1:0]    r_gnt, w_gnt, r_done, w_done;
  logic                  r_err, w_err;
  logic                  w_found, w_finish;
  logic [WIN_W-1:0]      w_pick, w_idx;

  // Search upward from the slot after the previous winner, wrapping around
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_last;
    w_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = WIN_W'((int'(r_last) + k) % NUM_REQ);
      if (!w_found && bus.req[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

  always_comb begin
    w_state   = r_state;
    w_last    = r_last;
    w_win     = r_win;
    w_cnt     = r_cnt;
    w_psel    = r_psel;
    w_penable = r_penable;
    w_pwrite  = r_pwrite;
    w_paddr   = r_paddr;
    w_pwdata  = r_pwdata;
    w_rdata   = r_rdata;
    w_gnt     = r_gnt;
    w_done    = '0;
    w_err     = 1'b0;
    w_finish  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state   = SETUP;
          w_win     = w_pick;
          w_cnt     = '0;
          w_psel    = 1'b1;
          w_penable = 1'b0;
          w_pwrite  = bus.req_write[w_pick];
          w_paddr   = bus.req_addr[w_pick*ADDR_WIDTH +: ADDR_WIDTH];
          w_pwdata  = bus.req_wdata[w_pick*DATA_WIDTH +: DATA_WIDTH];
          w_gnt     = NUM_REQ'(1) << w_pick;
        end
      end
      SETUP: begin
        w_penable = 1'b1;
        w_state   = ACCESS;
      end
      ACCESS: begin
        if (bus.pready) begin
          w_finish = 1'b1;
          w_err    = bus.pslverr;
          if (!r_pwrite) w_rdata = bus.prdata;
        end else if ((TIMEOUT != 0) && (r_cnt == CNT_W'(TIMEOUT - 1))) begin
          w_finish = 1'b1;
          w_err    = 1'b1;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      default: w_state = IDLE;
    endcase
    // Normal completion and timeout abort retire the transfer identically
    if (w_finish) begin
      w_state   = IDLE;
      w_psel    = 1'b0;
      w_penable = 1'b0;
      w_pwrite  = 1'b0;
      w_gnt     = '0;
      w_done    = r_gnt;
      w_last    = r_win;
    end
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_last    <= WIN_W'(NUM_REQ - 1);
      r_win     <= '0;
      r_cnt     <= '0;
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_pwrite  <= 1'b0;
      r_paddr   <= '0;
      r_pwdata  <= '0;
      r_rdata   <= '0;
      r_gnt     <= '0;
      r_done    <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_last    <= w_last;
      r_win     <= w_win;
      r_cnt     <= w_cnt;
      r_psel    <= w_psel;
      r_penable <= w_penable;
      r_pwrite  <= w_pwrite;
      r_paddr   <= w_paddr;
      r_pwdata  <= w_pwdata;
      r_rdata   <= w_rdata;
      r_gnt     <= w_gnt;
      r_done    <= w_done;
      r_err     <= w_err;
    end
  end

  assign bus.psel    = r_psel;
  assign bus.penable = r_penable;
  assign bus.pwrite  = r_pwrite;
  assign bus.paddr   = r_paddr;
  assign bus.pwdata  = r_pwdata;
  assign bus.rdata   = r_rdata;
  assign bus.gnt     = r_gnt;
  assign bus.done    = r_done;
  assign bus.err     = r_err;

endmodule

`default_nettype wire
